// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one word from the TX FIFO per frame and shifts it
// out as start, data (LSB first), optional parity and stop bits on txd.
module uart_tx_serializer #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    output logic                  pop_en,
    input  logic [DATA_WIDTH-1:0] pop_data,
    input  logic                  pop_avail,
    output logic                  txd,
    output logic                  busy
);

    localparam int unsigned       DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned       BIT_W       = $clog2(DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST   = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST   = BIT_W'(STOP_BITS - 1);
    localparam logic              PAR_ODD_BIT = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                r_state;
    state_t                w_state;
    logic [DIV_W-1:0]      r_div;
    logic [DIV_W-1:0]      w_div;
    logic [BIT_W-1:0]      r_bit;
    logic [BIT_W-1:0]      w_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift;
    logic                  r_parity;
    logic                  w_parity;
    logic                  r_txd;
    logic                  w_txd;
    logic                  r_busy;
    logic                  w_busy;
    logic                  r_pop_en;
    logic                  w_pop_en;
    logic                  w_bit_end;

    assign w_bit_end = (r_div == DIV_LAST);

    // State and datapath registers; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_div    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_txd    <= 1'b1;
            r_busy   <= 1'b0;
            r_pop_en <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_div    <= w_div;
            r_bit    <= w_bit;
            r_shift  <= w_shift;
            r_parity <= w_parity;
            r_txd    <= w_txd;
            r_busy   <= w_busy;
            r_pop_en <= w_pop_en;
        end
    end

    // Next-state and next-output logic; every line value is decided one cycle ahead.
    always_comb begin
        w_state  = r_state;
        w_div    = r_div;
        w_bit    = r_bit;
        w_shift  = r_shift;
        w_parity = r_parity;
        w_txd    = r_txd;
        w_busy   = r_busy;
        w_pop_en = 1'b0;

        case (r_state)
            IDLE: begin
                w_txd  = 1'b1;
                w_busy = 1'b0;
                if (tx_en && pop_avail) begin
                    w_pop_en = 1'b1;
                    w_busy   = 1'b1;
                    w_state  = FETCH;
                end
            end
            // FIFO data becomes valid during this cycle; latch it and drop into the start bit.
            FETCH: begin
                w_shift  = pop_data;
                w_parity = (^pop_data) ^ PAR_ODD_BIT;
                w_txd    = 1'b0;
                w_div    = '0;
                w_bit    = '0;
                w_state  = START;
            end
            START: begin
                if (w_bit_end) begin
                    w_div   = '0;
                    w_txd   = r_shift[0];
                    w_shift = r_shift >> 1;
                    w_state = DATA;
                end else begin
                    w_div = r_div + DIV_W'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_div = '0;
                    if (r_bit == DATA_LAST) begin
                        w_bit = '0;
                        if (PARITY_EN != 0) begin
                            w_txd   = r_parity;
                            w_state = PARITY;
                        end else begin
                            w_txd   = 1'b1;
                            w_state = STOP;
                        end
                    end else begin
                        w_bit   = r_bit + BIT_W'(1);
                        w_txd   = r_shift[0];
                        w_shift = r_shift >> 1;
                    end
                end else begin
                    w_div = r_div + DIV_W'(1);
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_div   = '0;
                    w_txd   = 1'b1;
                    w_state = STOP;
                end else begin
                    w_div = r_div + DIV_W'(1);
                end
            end
            // Multiple stop bits reuse the bit counter.
            STOP: begin
                w_txd = 1'b1;
                if (w_bit_end) begin
                    w_div = '0;
                    if (r_bit == STOP_LAST) begin
                        w_bit   = '0;
                        w_busy  = 1'b0;
                        w_state = IDLE;
                    end else begin
                        w_bit = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_div = r_div + DIV_W'(1);
                end
            end
            default: begin
                w_state = IDLE;
                w_div   = '0;
                w_bit   = '0;
                w_txd   = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign pop_en = r_pop_en;
    assign txd    = r_txd;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations share one clock and reset, each fed
// by a FIFO model; captured cycle traces are compared against a frame-level reference.
module tb_uart_tx_serializer;

    localparam int NI  = 4;
    localparam int TRW = 512;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en     [NI];
    logic       pop_en    [NI];
    logic [7:0] pop_data  [NI];
    logic       pop_avail [NI];
    logic       txd       [NI];
    logic       busy      [NI];

    logic [7:0] mem [NI][64];
    int         wr  [NI];
    int         rd  [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instance 0: div 4 no parity; 1: even parity; 2: odd parity; 3: div 16, two stop bits.
    uart_tx_serializer #(.CLK_DIV(4), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .tx_en(tx_en[0]), .pop_en(pop_en[0]), .pop_data(pop_data[0]),
        .pop_avail(pop_avail[0]), .txd(txd[0]), .busy(busy[0]));
    uart_tx_serializer #(.CLK_DIV(4), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en[1]), .pop_en(pop_en[1]), .pop_data(pop_data[1]),
        .pop_avail(pop_avail[1]), .txd(txd[1]), .busy(busy[1]));
    uart_tx_serializer #(.CLK_DIV(4), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .tx_en(tx_en[2]), .pop_en(pop_en[2]), .pop_data(pop_data[2]),
        .pop_avail(pop_avail[2]), .txd(txd[2]), .busy(busy[2]));
    uart_tx_serializer #(.CLK_DIV(16), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .tx_en(tx_en[3]), .pop_en(pop_en[3]), .pop_data(pop_data[3]),
        .pop_avail(pop_avail[3]), .txd(txd[3]), .busy(busy[3]));

    function automatic int cdiv(input int k);
        return (k == 3) ? 16 : 4;
    endfunction
    function automatic bit cpe(input int k);
        return (k == 1) || (k == 2);
    endfunction
    function automatic bit cpo(input int k);
        return (k == 2);
    endfunction
    function automatic int csb(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    // FIFO model: pops on falling clk; read data is garbage except right after a pop.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (pop_en[k] === 1'b1) begin
                pop_data[k] <= mem[k][rd[k] % 64];
                rd[k]       <= rd[k] + 1;
            end else begin
                pop_data[k] <= 8'($urandom);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NI; k++) pop_avail[k] = (wr[k] != rd[k]);
    end

    task automatic push(input int k, input logic [7:0] b);
        mem[k][wr[k] % 64] = b;
        wr[k] = wr[k] + 1;
    endtask

    task automatic flush(input int k);
        wr[k] = rd[k];
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pop(input int k, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (pop_en[k] === 1'b1) seen = 1'b1;
        end
    endtask

    // Records n cycles of txd/busy/pop_en starting at the cycle where pop_en is first seen.
    task automatic capture(input int k, input int n, output logic [TRW-1:0] t,
                           output logic [TRW-1:0] b, output logic [TRW-1:0] p, output bit seen);
        t = '1;
        b = '0;
        p = '0;
        wait_pop(k, 200, seen);
        if (seen) begin
            for (int i = 0; i < n; i++) begin
                if (i > 0) begin
                    @(posedge clk);
                    #1;
                end
                t[i] = txd[k];
                b[i] = busy[k];
                p[i] = pop_en[k];
            end
        end
    endtask

    // Reference: per word a pop cycle, then each frame bit held cdiv cycles, then one idle cycle.
    function automatic void build_expect(input int k, input logic [7:0] q[$], output logic [TRW-1:0] et,
                                         output logic [TRW-1:0] eb, output logic [TRW-1:0] ep);
        int         idx;
        bit         fb[$];
        logic [7:0] d;
        et  = '1;
        eb  = '0;
        ep  = '0;
        idx = 0;
        foreach (q[f]) begin
            d = q[f];
            fb.delete();
            fb.push_back(1'b0);
            for (int i = 0; i < 8; i++) fb.push_back(d[i]);
            if (cpe(k)) fb.push_back(cpo(k) ? ~(^d) : (^d));
            for (int s = 0; s < csb(k); s++) fb.push_back(1'b1);
            if (idx < TRW) begin
                ep[idx] = 1'b1;
                eb[idx] = 1'b1;
            end
            idx++;
            foreach (fb[j]) begin
                for (int c = 0; c < cdiv(k); c++) begin
                    if (idx < TRW) begin
                        et[idx] = fb[j];
                        eb[idx] = 1'b1;
                    end
                    idx++;
                end
            end
            idx++;
        end
    endfunction

    task automatic test_reset();
        logic [TRW-1:0] t, b, p, et, eb, ep;
        logic [7:0]     q[$];
        logic [9:0]     bits;
        bit             seen;
        rst = 1'b1;
        tick(3);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (txd[k] !== 1'b1 || busy[k] !== 1'b0 || pop_en[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d] txd=%b busy=%b pop_en=%b required 1/0/0", k, txd[k], busy[k], pop_en[k]);
            end
        end
        push(0, 8'hA5);
        rst      = 1'b0;
        tx_en[0] = 1'b1;
        capture(0, 48, t, b, p, seen);
        tx_en[0] = 1'b0;
        q = {8'hA5};
        build_expect(0, q, et, eb, ep);
        checks++;
        if (!seen) begin errors++; $display("FAIL one_byte_pop seen=0 required=1"); end
        checks++;
        if (t !== et) begin errors++; $display("FAIL one_byte_txd got=%h required=%h", t, et); end
        checks++;
        if (b !== eb) begin errors++; $display("FAIL one_byte_busy got=%h required=%h", b, eb); end
        checks++;
        if (p !== ep) begin errors++; $display("FAIL one_byte_pop_en got=%h required=%h", p, ep); end
        for (int i = 0; i < 10; i++) bits[i] = t[1 + 4 * i + 2];
        checks++;
        if (bits !== 10'h34A) begin errors++; $display("FAIL one_byte_bits got=%h required=34a", bits); end
        checks++;
        if ($countones(b) != 41) begin errors++; $display("FAIL one_byte_busy_len got=%0d required=41", $countones(b)); end
    endtask

    task automatic test_parity();
        logic [TRW-1:0] t, b, p, et, eb, ep;
        logic [7:0]     q[$];
        bit             seen;
        for (int k = 1; k <= 2; k++) begin
            push(k, 8'hA5);
            tx_en[k] = 1'b1;
            capture(k, 52, t, b, p, seen);
            tx_en[k] = 1'b0;
            q = {8'hA5};
            build_expect(k, q, et, eb, ep);
            checks++;
            if (!seen) begin errors++; $display("FAIL parity%0d_pop seen=0 required=1", k); end
            checks++;
            if (t !== et) begin errors++; $display("FAIL parity%0d_txd got=%h required=%h", k, t, et); end
            checks++;
            if (b !== eb || p !== ep) begin
                errors++;
                $display("FAIL parity%0d_ctl busy=%h pop=%h required busy=%h pop=%h", k, b, p, eb, ep);
            end
            checks++;
            if (t[39] !== ((k == 2) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL parity%0d_bit got=%b required=%b", k, t[39], (k == 2));
            end
            checks++;
            if ($countones(b) != 45) begin errors++; $display("FAIL parity%0d_len got=%0d required=45", k, $countones(b)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [TRW-1:0] t, b, p, et, eb, ep;
        logic [7:0]     q[$];
        bit             seen;
        q = {8'h00, 8'hFF, 8'h3C};
        foreach (q[i]) push(0, q[i]);
        tx_en[0] = 1'b1;
        capture(0, 130, t, b, p, seen);
        tx_en[0] = 1'b0;
        build_expect(0, q, et, eb, ep);
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_pop seen=0 required=1"); end
        checks++;
        if (t !== et) begin errors++; $display("FAIL b2b_txd got=%h required=%h", t, et); end
        checks++;
        if (b !== eb) begin errors++; $display("FAIL b2b_busy got=%h required=%h", b, eb); end
        checks++;
        if ($countones(p) != 3 || p[42] !== 1'b1 || p[84] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pop_spacing got=%h required pulses at 0,42,84", p);
        end
    endtask

    task automatic test_flow();
        logic [TRW-1:0] t, b, p, et, eb, ep;
        logic [7:0]     q[$];
        logic [7:0]     r1, r2;
        bit             seen;
        int             bad;
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        push(0, r1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (pop_en[0] !== 1'b0 || txd[0] !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL flow_disabled bad_cycles=%0d required=0", bad); end
        push(0, r2);
        tx_en[0] = 1'b1;
        fork
            capture(0, 90, t, b, p, seen);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk);
                    #1;
                    if (pop_en[0] === 1'b1) break;
                end
                repeat (10) @(posedge clk);
                #2 tx_en[0] = 1'b0;
            end
        join
        q = {r1};
        build_expect(0, q, et, eb, ep);
        checks++;
        if (!seen) begin errors++; $display("FAIL flow_pop seen=0 required=1"); end
        checks++;
        if (t !== et) begin errors++; $display("FAIL flow_txd got=%h required=%h", t, et); end
        checks++;
        if (p !== ep || b !== eb) begin
            errors++;
            $display("FAIL flow_ctl pop=%h busy=%h required pop=%h busy=%h", p, b, ep, eb);
        end
        flush(0);
    endtask

    task automatic test_reset_midframe();
        logic [TRW-1:0] t, b, p, et, eb, ep;
        logic [7:0]     q[$];
        logic [7:0]     b0, b1;
        bit             seen;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        push(0, b0);
        push(0, b1);
        tx_en[0] = 1'b1;
        wait_pop(0, 50, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL midrst_pop seen=0 required=1"); end
        tick(18);
        checks++;
        if (txd[0] !== b0[3]) begin errors++; $display("FAIL midrst_bit3 got=%b required=%b", txd[0], b0[3]); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || pop_en[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async txd=%b busy=%b pop_en=%b required 1/0/0", txd[0], busy[0], pop_en[0]);
        end
        tick(3);
        rst = 1'b0;
        capture(0, 48, t, b, p, seen);
        tx_en[0] = 1'b0;
        q = {b1};
        build_expect(0, q, et, eb, ep);
        checks++;
        if (!seen) begin errors++; $display("FAIL midrst_restart seen=0 required=1"); end
        checks++;
        if (t !== et || b !== eb || p !== ep) begin
            errors++;
            $display("FAIL midrst_frame txd=%h required=%h", t, et);
        end
    endtask

    task automatic test_stop2();
        logic [TRW-1:0] t, b, p, et, eb, ep;
        logic [7:0]     q[$];
        bit             seen;
        int             lows, highs, next_start;
        q = {8'h01, 8'($urandom)};
        foreach (q[i]) push(3, q[i]);
        tx_en[3] = 1'b1;
        capture(3, 400, t, b, p, seen);
        tx_en[3] = 1'b0;
        build_expect(3, q, et, eb, ep);
        checks++;
        if (!seen) begin errors++; $display("FAIL stop2_pop seen=0 required=1"); end
        checks++;
        if (t !== et) begin errors++; $display("FAIL stop2_txd got=%h required=%h", t, et); end
        checks++;
        if (b !== eb || p !== ep) begin
            errors++;
            $display("FAIL stop2_ctl busy=%h pop=%h required busy=%h pop=%h", b, p, eb, ep);
        end
        lows = 0;
        highs = 0;
        for (int i = 1; i <= 16; i++) if (t[i] === 1'b0) lows++;
        for (int i = 17; i <= 32; i++) if (t[i] === 1'b1) highs++;
        for (int i = 33; i <= 144; i++) if (t[i] === 1'b0) lows++;
        checks++;
        if (lows != 128 || highs != 16) begin
            errors++;
            $display("FAIL stop2_runs lows=%0d highs=%0d required lows=128 highs=16", lows, highs);
        end
        next_start = -1;
        for (int i = 145; i < 400 && next_start < 0; i++) if (t[i] !== 1'b1) next_start = i;
        checks++;
        if (next_start != 179) begin errors++; $display("FAIL stop2_gap next_start=%0d required=179", next_start); end
    endtask

    task automatic test_random();
        logic [TRW-1:0] t, b, p, et, eb, ep;
        logic [7:0]     q[$];
        bit             seen;
        for (int k = 0; k <= 1; k++) begin
            q.delete();
            for (int i = 0; i < 4 - k; i++) q.push_back(8'($urandom));
            foreach (q[i]) push(k, q[i]);
            tx_en[k] = 1'b1;
            capture(k, (k == 0) ? 172 : 142, t, b, p, seen);
            tx_en[k] = 1'b0;
            build_expect(k, q, et, eb, ep);
            checks++;
            if (!seen) begin errors++; $display("FAIL random%0d_pop seen=0 required=1", k); end
            checks++;
            if (t !== et) begin errors++; $display("FAIL random%0d_txd got=%h required=%h", k, t, et); end
            checks++;
            if (b !== eb || p !== ep) begin
                errors++;
                $display("FAIL random%0d_ctl busy=%h pop=%h required busy=%h pop=%h", k, b, p, eb, ep);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            tx_en[k] = 1'b0;
            wr[k]    = 0;
        end
        test_reset();
        test_parity();
        test_back_to_back();
        test_flow();
        test_reset_midframe();
        test_stop2();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
